// File: rtl/dm_responder.sv
// dm_responder: round-robin arbitrated shared data-memory responder, one access every two cycles.
// Optional macro DM_ERR_CNT_EN adds o_err_cnt, a saturating count of out-of-range accesses.
module dm_responder #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [NUM_CORES-1:0]        i_wr,
  input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
  input  logic [NUM_CORES*DATA_W-1:0] i_wdata,
  output logic [NUM_CORES-1:0]        o_gnt,
  output logic [NUM_CORES-1:0]        o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_busy,
  output logic                        o_err
`ifdef DM_ERR_CNT_EN
  ,
  output logic [15:0]                 o_err_cnt
`endif
);
  localparam int IDX_W  = $clog2(NUM_CORES);
  localparam int MEM_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_found;
  logic                 w_take;
  logic                 r_wr;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic                 w_in_range;
  logic [MEM_AW-1:0]    w_mem_addr;
  logic [NUM_CORES-1:0] w_win_onehot;
  logic [NUM_CORES-1:0] w_idx_onehot;
  logic [NUM_CORES-1:0] r_gnt;
  logic [NUM_CORES-1:0] r_rvalid;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_busy;
  logic                 r_err;
`ifdef DM_ERR_CNT_EN
  logic [15:0]          r_err_cnt;
`endif

  // Range check uses the full address; truncation to the RAM index happens only afterwards
  assign w_in_range = ({1'b0, r_addr} < (ADDR_W+1)'(DEPTH));
  assign w_mem_addr = r_addr[MEM_AW-1:0];

  // Round-robin pick: first requester at or above r_rr_ptr, wrapping
  always_comb begin : arb
    int j;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    j           = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = (int'(r_rr_ptr) + k) % NUM_CORES;
      if (!w_win_found && i_req[j]) begin
        w_win_found = 1'b1;
        w_win_idx   = IDX_W'(j);
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  // One-hot decodes of the new winner and of the access being served
  always_comb begin
    w_win_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_win_idx;
    w_idx_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << r_idx;
  end

  // Next-state logic; RESP arbitrates like IDLE so back-to-back accesses need no gap
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_win_found) begin
          w_next_state = S_SERVE;
          w_take       = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SERVE: w_next_state = S_RESP;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, request latch, round-robin pointer and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
`ifdef DM_ERR_CNT_EN
      r_err_cnt <= 16'd0;
`endif
    end else begin
      r_state  <= w_next_state;
      r_busy   <= (w_next_state != S_IDLE);
      r_gnt    <= '0;
      r_rvalid <= '0;
      if (w_take) begin
        r_idx   <= w_win_idx;
        r_wr    <= i_wr[w_win_idx];
        r_addr  <= i_addr[w_win_idx*ADDR_W +: ADDR_W];
        r_wdata <= i_wdata[w_win_idx*DATA_W +: DATA_W];
        r_gnt   <= w_win_onehot;
      end
      if (r_state == S_SERVE) begin
        r_rr_ptr <= (r_idx == IDX_W'(NUM_CORES-1)) ? '0 : r_idx + 1'b1;
        if (!r_wr) begin
          r_rvalid <= w_idx_onehot;
          r_rdata  <= w_in_range ? r_mem[w_mem_addr] : '0;
        end
        if (!w_in_range) begin
          r_err <= 1'b1;
`ifdef DM_ERR_CNT_EN
          if (r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
          end
`endif
        end
      end
    end
  end

  // RAM write port; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (r_state == S_SERVE && r_wr && w_in_range) begin
      r_mem[w_mem_addr] <= r_wdata;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_busy   = r_busy;
  assign o_err    = r_err;
`ifdef DM_ERR_CNT_EN
  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: cycle-schedule reference model plus directed scenarios.
module tb_dm_responder;
  localparam int N    = 4;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;
  logic        err;
`ifdef DM_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  dm_responder #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8), .DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_wr     (wr),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_gnt    (gnt),
    .o_rvalid (rvalid),
    .o_rdata  (rdata),
    .o_busy   (busy),
    .o_err    (err)
`ifdef DM_ERR_CNT_EN
    ,
    .o_err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecount = 0;
  bit started = 1'b0;

  // Reference model: each granted access schedules its outputs on future cycle slots
  logic [7:0] mmem [256];
  bit [3:0]   e_gnt    [MAXC];
  bit [3:0]   e_rvalid [MAXC];
  bit         e_busy   [MAXC];
  bit         rd_set   [MAXC];
  bit [7:0]   rd_val   [MAXC];
  bit         er_set   [MAXC];
  int         rr = 0;
  int         next_pick = 0;
  bit [7:0]   cur_rdata = 8'h00;
  bit         cur_err = 1'b0;
  int         cur_ecnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ecount = ecount + 1;
    if (ecount < MAXC - 4) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          e_gnt[ecount+k] = 4'd0; e_rvalid[ecount+k] = 4'd0; e_busy[ecount+k] = 1'b0;
          rd_set[ecount+k] = 1'b0; er_set[ecount+k] = 1'b0;
        end
        rr = 0;
        next_pick = 0;
      end else if (ecount >= next_pick && req != 4'd0) begin
        int w;
        int a;
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
        end
        a = int'(addr[w*16 +: 16]);
        e_gnt[ecount] = 4'(1 << w);
        e_busy[ecount] = 1'b1;
        e_busy[ecount+1] = 1'b1;
        if (wr[w]) begin
          if (a < 256) mmem[a] = wdata[w*8 +: 8];
        end else begin
          e_rvalid[ecount+1] = 4'(1 << w);
          rd_set[ecount+1] = 1'b1;
          rd_val[ecount+1] = (a < 256) ? mmem[a] : 8'h00;
        end
        if (a >= 256) er_set[ecount+1] = 1'b1;
        rr = (w + 1) % N;
        next_pick = ecount + 2;
      end
    end
  end

  // Single compare process: every cycle, mid-period
  always @(negedge clk) begin
    if (started && ecount < MAXC - 4) begin
      if (rst) begin
        cur_rdata = 8'h00;
        cur_err = 1'b0;
        cur_ecnt = 0;
        chk("reset_outputs", {gnt, rvalid, busy, err, rdata}, 32'd0);
      end else begin
        if (rd_set[ecount]) cur_rdata = rd_val[ecount];
        if (er_set[ecount]) begin
          cur_err = 1'b1;
          if (cur_ecnt < 65535) cur_ecnt++;
        end
        chk("cycle", {gnt, rvalid, busy, err, rdata},
            {e_gnt[ecount], e_rvalid[ecount], e_busy[ecount], cur_err, cur_rdata});
`ifdef DM_ERR_CNT_EN
        chk("cycle_err_cnt", {16'd0, err_cnt}, 32'(cur_ecnt));
`endif
      end
    end
  end

  task automatic tick();
    logic [3:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    req = req & ~g;
  endtask

  task automatic post(input int c, input bit w, input logic [15:0] a, input logic [7:0] d);
    req[c] = 1'b1;
    wr[c] = w;
    addr[c*16 +: 16] = a;
    wdata[c*8 +: 8] = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req != 4'd0 || busy) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=busy expected=idle at t=%0t", $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] g_log  [9];
  logic [3:0] rv_log [9];
  logic [7:0] rd_log [9];

  initial begin
    rst = 1'b0; req = 4'd0; wr = 4'd0; addr = 64'd0; wdata = 32'd0;
    #1;
    rst = 1'b1;
    started = 1'b1;
    #1;
    chk("reset_state", {gnt, rvalid, busy, err, rdata}, 32'd0);
    do_reset();

    // 1: core0 write A5 @0x10, then read it back
    post(0, 1'b1, 16'h0010, 8'hA5);
    tick(); chk("t1_wr_gnt", gnt, 4'b0001);
    tick(); chk("t1_wr_no_rvalid", rvalid, 4'b0000);
    post(0, 1'b0, 16'h0010, 8'h00);
    tick(); chk("t1_rd_gnt", gnt, 4'b0001);
    tick(); chk("t1_rd_rvalid", rvalid, 4'b0001); chk("t1_rd_data", rdata, 8'hA5);
    drain();

    // 2: simultaneous requests from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) post(i, 1'b1, 16'(16'h0020 + i), 8'(8'h40 + i));
    drain();
    for (int i = 0; i < 4; i++) post(i, 1'b0, 16'(16'h0020 + i), 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      g_log[k] = gnt; rv_log[k] = rvalid; rd_log[k] = rdata;
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_gnt_order", g_log[2*i+1], 32'(1 << i));
      chk("t2_rvalid", rv_log[2*i+2], 32'(1 << i));
      chk("t2_rdata", rd_log[2*i+2], 32'(8'h40 + i));
    end
    drain();

    // 3: after core2, round-robin wraps to core3 ahead of core1
    post(2, 1'b0, 16'h0022, 8'h00);
    drain();
    post(1, 1'b0, 16'h0021, 8'h00);
    post(3, 1'b0, 16'h0023, 8'h00);
    tick(); chk("t3_first_gnt", gnt, 4'b1000);
    tick(); tick(); chk("t3_second_gnt", gnt, 4'b0010);
    drain();

    // 4: out-of-range write and read
    post(0, 1'b1, 16'h0000, 8'h77);
    drain();
    post(1, 1'b1, 16'h0100, 8'h3C);
    tick(); chk("t4_oor_gnt", gnt, 4'b0010);
    tick(); chk("t4_err", err, 1'b1);
`ifdef DM_ERR_CNT_EN
    chk("t4_err_cnt", err_cnt, 16'd1);
`endif
    drain();
    post(2, 1'b0, 16'h0000, 8'h00);
    tick(); tick(); chk("t4_addr0_unchanged", rdata, 8'h77);
    drain();
    post(3, 1'b0, 16'h0100, 8'h00);
    tick(); tick(); chk("t4_oor_rvalid", rvalid, 4'b1000); chk("t4_oor_rdata", rdata, 8'h00);
    drain();

    // 5: reset during SERVE of a read
    post(0, 1'b0, 16'h0010, 8'h00);
    tick(); chk("t5_serve_gnt", {gnt, busy}, 5'b0001_1);
    rst = 1'b1;
    req = 4'd0;
    #1;
    chk("t5_async_drop", {gnt, rvalid, busy, err}, 10'd0);
    tick(); chk("t5_no_rvalid", rvalid, 4'b0000);
    tick();
    rst = 1'b0;
    tick(); chk("t5_idle", {busy, rvalid}, 5'd0);

    // 6: write then read of the same address in consecutive accesses
    post(0, 1'b1, 16'h0005, 8'h11);
    post(1, 1'b0, 16'h0005, 8'h00);
    tick(); chk("t6_wr_gnt", gnt, 4'b0001);
    tick(); tick(); chk("t6_rd_gnt", gnt, 4'b0010);
    tick(); chk("t6_rvalid", rvalid, 4'b0010); chk("t6_rdata", rdata, 8'h11);
    tick(); tick(); tick(); chk("t6_rdata_hold", {rvalid, rdata}, 12'h011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
